// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle integer divider.
//   - div_state_e   : controller state encoding (IDLE / ITER / FIX)
//   - DIV_DEFAULT_WIDTH : default operand width
//   - div_cnt_width : width of the iteration counter for a given WIDTH
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  localparam int DIV_DEFAULT_WIDTH = 32;

  // The counter must be able to hold the value WIDTH.
  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/twos_abs.sv
// Combinational two's-complement magnitude / conditional negation unit.
// Ports:
//   data_i    : value to condition
//   use_msb_i : 1 = negate when data_i is negative (magnitude mode)
//   neg_req_i : negate request used when use_msb_i = 0 (fix-up mode)
//   mag_o     : data_i or its two's-complement negation
//   sign_o    : 1 when mag_o is the negated value
module twos_abs
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             use_msb_i,
  input  logic             neg_req_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);

  logic negate;

  assign negate = use_msb_i ? data_i[WIDTH-1] : neg_req_i;
  // The most negative value maps onto itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1).
  assign mag_o  = negate ? ((~data_i) + {{(WIDTH-1){1'b0}}, 1'b1}) : data_i;
  assign sign_o = negate;

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle restoring divider with fixed latency of WIDTH+1 clock edges.
// Operands are converted to magnitudes at load, WIDTH restoring iterations
// produce an unsigned quotient/remainder, and a final step restores signs
// (truncating division) and registers the results.
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   ctrl_div        : start strobe, only honoured while idle
//   data_operandA/B : dividend / divisor, sampled with ctrl_div
//   data_result     : quotient
//   data_remainder  : remainder
//   data_exception  : divide-by-zero flag (valid with data_resultRDY)
//   data_overflow   : signed MIN / -1 flag (valid with data_resultRDY)
//   data_resultRDY  : one-cycle completion pulse
//   busy            : operation in progress
module signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_overflow,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int               CNT_W    = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exc_q, exc_d;
  logic             ovf_out_q, ovf_out_d;
  logic             rdy_q, rdy_d;

  // Shared sign units: operands while idle, quotient/remainder afterwards.
  logic             load_mode;
  logic [WIDTH-1:0] abs_a_in, abs_b_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sgn_a, sgn_b;
  logic             neg_quo, neg_rem;

  assign load_mode = (state_q == DIV_IDLE);
  assign abs_a_in  = load_mode ? data_operandA : quo_q;
  assign abs_b_in  = load_mode ? data_operandB : rem_q;
  assign neg_quo   = !load_mode && SIGNED && (sign_a_q ^ sign_b_q);
  assign neg_rem   = !load_mode && SIGNED && sign_a_q;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .data_i    (abs_a_in),
    .use_msb_i (load_mode && SIGNED),
    .neg_req_i (neg_quo),
    .mag_o     (mag_a),
    .sign_o    (sgn_a)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .data_i    (abs_b_in),
    .use_msb_i (load_mode && SIGNED),
    .neg_req_i (neg_rem),
    .mag_o     (mag_b),
    .sign_o    (sgn_b)
  );

  // Restoring step: partial remainder is always below the divisor, so the
  // shifted value minus the divisor fits WIDTH+1 bits with bit WIDTH as sign.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;
  logic           trial_ok;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, divisor_q};
  assign trial_ok  = ~trial[WIDTH];

  logic op_overflow;
  assign op_overflow = SIGNED && (data_operandA == MIN_VAL) && (&data_operandB);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    dividend_d  = dividend_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exc_d       = exc_q;
    ovf_out_d   = ovf_out_q;
    rdy_d       = 1'b0;

    case (state_q)
      // Load: capture magnitudes, signs and exception flags.
      DIV_IDLE: begin
        if (ctrl_div) begin
          quo_d      = mag_a;
          divisor_d  = mag_b;
          dividend_d = data_operandA;
          sign_a_d   = sgn_a;
          sign_b_d   = sgn_b;
          dz_d       = (data_operandB == '0);
          ovf_d      = op_overflow;
          rem_d      = '0;
          count_d    = '0;
          state_d    = DIV_ITER;
        end
      end

      // Iterate: one quotient bit per edge, WIDTH edges in total.
      DIV_ITER: begin
        rem_d   = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], trial_ok};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          state_d = DIV_FIX;
        end
      end

      // Fix-up: restore signs, apply divide-by-zero override, publish.
      DIV_FIX: begin
        if (dz_q) begin
          result_d    = '0;
          remainder_d = dividend_q;
          exc_d       = 1'b1;
          ovf_out_d   = 1'b0;
        end else begin
          result_d    = mag_a;
          remainder_d = mag_b;
          exc_d       = 1'b0;
          ovf_out_d   = ovf_q;
        end
        rdy_d   = 1'b1;
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      dividend_q  <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exc_q       <= 1'b0;
      ovf_out_q   <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      dividend_q  <= dividend_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
      ovf_out_q   <= ovf_out_d;
      rdy_q       <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_remainder = remainder_q;
  assign data_exception = exc_q;
  assign data_overflow  = ovf_out_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != DIV_IDLE);

endmodule

// File: doc/signed_divider.md
# signed_divider

Parametrised multi-cycle integer divider for the CPU's multdiv path. Operand sign conditioning (two's-complement magnitude) is folded into the load step. A restoring iteration follows, then a sign fix-up stage. A start/ready handshake lets the pipeline stall on divide instructions with a fixed, data-independent latency. Divide-by-zero and signed overflow are flagged.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4).
- SIGNED, 1, 1 = two's-complement operands; 0 = unsigned operands, no conditioning or fix-up.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- ctrl_div  in  1  start strobe, sampled only in IDLE
- data_operandA  in  WIDTH  dividend, sampled with ctrl_div
- data_operandB  in  WIDTH  divisor, sampled with ctrl_div
- data_result  out  WIDTH  quotient
- data_remainder  out  WIDTH  remainder
- data_exception  out  1  divide-by-zero flag, valid with data_resultRDY
- data_overflow  out  1  signed MIN / −1 flag, valid with data_resultRDY
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high in ITER and FIX

## Operation
- States: IDLE, ITER, FIX.
- IDLE, ctrl_div=1 at an edge:
  - latch |A| and |B| (SIGNED=1: negate when MSB set; unsigned WIDTH-bit result, so MIN maps to 2^(WIDTH−1));
  - latch signA, signB, zero-divisor flag, overflow flag;
  - clear partial remainder; count=0; go to ITER.
- ITER, per edge:
  - shift {rem, quo} left 1;
  - trial = rem − |B| in WIDTH+1 bits;
  - if trial is non-negative: rem = trial and quotient LSB = 1;
  - count++; after WIDTH iterations go to FIX.
- FIX, one edge:
  - quotient negated if signA^signB; remainder negated if signA (truncating division);
  - register outputs; data_resultRDY=1; go to IDLE.
- Divide-by-zero: iterations still run (fixed latency). At FIX, force result=0, remainder=dividend (original, unconditioned), data_exception=1, data_overflow=0.
- Overflow (SIGNED=1, A=MIN, B=−1): result=MIN, remainder=0, data_overflow=1. This falls out of the magnitude path; the flag is the only addition.
- SIGNED=0: no negation anywhere; data_overflow is always 0.
- ctrl_div in ITER/FIX: ignored; operands are not resampled.

## Timing
- Reset values: data_result=0, data_remainder=0, data_exception=0, data_overflow=0, data_resultRDY=0, busy=0, state=IDLE, count=0.
- ctrl_div sampled at edge E0 → busy high from E0 until edge E(WIDTH+1).
- data_resultRDY high for exactly one cycle after E(WIDTH+1).
  - Latency: WIDTH+1 edges; WIDTH=32 gives 33.
- data_result, data_remainder and the flags hold their values until the next FIX edge.
  - They are not cleared by data_resultRDY falling.
- The data_resultRDY cycle is in IDLE, so ctrl_div asserted then is accepted (back-to-back operation). In that case data_resultRDY falls and busy rises at the same edge.
- Reset asserted mid-operation: immediate return to reset values; the in-flight result is discarded and no data_resultRDY pulse is produced.
- Operand inputs may change freely after E0.

## Structure
- Shared package `div_pkg`:
  - state encodings DIV_IDLE, DIV_ITER, DIV_FIX;
  - DIV_DEFAULT_WIDTH=32;
  - counter width function clog2(WIDTH+1).
- Sub-module `twos_abs` (parameter WIDTH): combinational magnitude-plus-sign. It is instantiated twice at load and reused for the FIX negations via its negate path.
- Remainder/quotient shift register and trial subtractor stay in the top module.

## Test plan
- WIDTH=32, SIGNED=1: 100/7 → result 14, remainder 2, data_resultRDY exactly 33 edges after start, exception=0.
- Sign matrix: −100/7 → −14, −2; 100/−7 → −14, 2; −100/−7 → 14, −2.
- 5/0 → result 0, remainder 5, data_exception=1, data_overflow=0, same 33-edge latency. Then 0x80000000/−1 → result 0x80000000, remainder 0, data_overflow=1.
- Start 100/7, pulse ctrl_div with 9/3 at cycle 10 → ignored; result 14/2. Then ctrl_div asserted during the data_resultRDY cycle with 9/3 → accepted; result 3, remainder 0 after 33 more edges.
- Reset asserted at cycle 15 of an operation → all outputs 0 immediately, no data_resultRDY pulse. A fresh 100/7 afterwards → 14, 2.
- SIGNED=0, WIDTH=8: 0xFF/0x10 → result 15, remainder 15, latency 9 edges, data_overflow=0.
